// File: rtl/vram_pkg.sv
// ============================================================================
// Package : vram_pkg
// Brief   : Shared VRAM types, tags and default bus widths.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package vram_pkg;

  localparam int VRAM_ADDR_W = 17;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_TURN = 2'd3
  } state_t;

  localparam logic TAG_HOST = 1'b0;
  localparam logic TAG_DISP = 1'b1;

endpackage

`default_nettype wire

// File: rtl/vram_arbiter_if.sv
// ============================================================================
// Interface : vram_arbiter_if
// Brief     : Display, host and SRAM signals around the VRAM arbiter.
// Rev       : 1.0  initial release
// ============================================================================
`default_nettype none

interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) ();

  logic              active_video;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_ack;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  active_video, disp_req, disp_addr,
    input  host_req, host_we, host_addr, host_wdata, mem_rdata,
    output disp_ack, disp_rdata, disp_rvalid,
    output host_ack, host_rdata, host_rvalid,
    output mem_ce, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output active_video, disp_req, disp_addr,
    output host_req, host_we, host_addr, host_wdata, mem_rdata,
    input  disp_ack, disp_rdata, disp_rvalid,
    input  host_ack, host_rdata, host_rvalid,
    input  mem_ce, mem_we, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/vram_rd_tag_pipe.sv
// ============================================================================
// Module : vram_rd_tag_pipe
// Brief  : MEM_LAT-deep {valid, is_disp} delay line that routes read returns.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vram_rd_tag_pipe
  import vram_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  wire logic clk,
  input  wire logic clr,
  input  wire logic in_valid,
  input  wire logic in_disp,
  output logic      disp_rvalid,
  output logic      host_rvalid
);

  logic [MEM_LAT-1:0] vld;
  logic [MEM_LAT-1:0] dsp;

  always_ff @(posedge clk) begin
    if (clr) begin
      vld <= '0;
      dsp <= '0;
    end else begin
      vld <= MEM_LAT'({vld, in_valid});
      dsp <= MEM_LAT'({dsp, in_valid && (in_disp == TAG_DISP)});
    end
  end

  assign disp_rvalid = vld[MEM_LAT-1] &&  dsp[MEM_LAT-1];
  assign host_rvalid = vld[MEM_LAT-1] && !dsp[MEM_LAT-1];

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module : vram_arbiter
// Brief  : Single-port video SRAM arbiter, display priority in active video,
//          round-robin in blanking, write turnaround insertion.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W   = VRAM_ADDR_W,
  parameter int DATA_W   = VRAM_DATA_W,
  parameter int MEM_LAT  = 2,
  parameter int TURN_CYC = 1
) (
  input wire logic      clk,
  input wire logic      nrst,
  vram_arbiter_if.slave bus
);

  localparam logic [1:0] TURN_LOAD = (TURN_CYC > 1) ? 2'(TURN_CYC - 2) : 2'd0;

  state_t            state, state_nxt;
  logic [1:0]        turn_cnt, turn_nxt;
  logic              rr_last;
  logic              can_grant, disp_ack, host_ack, xfer, xfer_wr;
  logic              mem_ce_q, mem_we_q, rd_issue_q, rd_disp_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              disp_rvalid, host_rvalid;

  // The S_WR cycle itself grants nothing, so the bus idles exactly TURN_CYC cycles after a write.
  assign can_grant = !nrst && ((state == S_IDLE) || (state == S_RD) ||
                               ((state == S_WR) && (TURN_CYC == 0)));

  always_comb begin
    disp_ack = 1'b0;
    host_ack = 1'b0;
    if (can_grant) begin
      disp_ack = bus.disp_req && (bus.active_video || !bus.host_req || (rr_last == TAG_HOST));
      host_ack = bus.host_req && !disp_ack &&
                 (!bus.active_video || (!bus.host_we && !bus.disp_req));
    end
  end

  assign xfer    = disp_ack || host_ack;
  assign xfer_wr = host_ack && bus.host_we;

  always_comb begin
    state_nxt = state;
    turn_nxt  = turn_cnt;
    unique case (state)
      S_TURN: begin
        if (turn_cnt == 2'd0) state_nxt = S_IDLE;
        else                  turn_nxt  = turn_cnt - 2'd1;
      end
      S_WR: begin
        if (TURN_CYC > 1) begin
          state_nxt = S_TURN;
          turn_nxt  = TURN_LOAD;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (xfer) state_nxt = xfer_wr ? S_WR : S_RD;
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state       <= S_IDLE;
      turn_cnt    <= 2'd0;
      rr_last     <= TAG_HOST;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_issue_q  <= 1'b0;
      rd_disp_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      turn_cnt    <= turn_nxt;
      if (xfer) rr_last <= disp_ack ? TAG_DISP : TAG_HOST;
      mem_ce_q    <= xfer;
      mem_we_q    <= xfer_wr;
      mem_addr_q  <= disp_ack ? bus.disp_addr : (host_ack ? bus.host_addr : '0);
      mem_wdata_q <= xfer_wr ? bus.host_wdata : '0;
      rd_issue_q  <= xfer && !xfer_wr;
      rd_disp_q   <= disp_ack ? TAG_DISP : TAG_HOST;
    end
  end

  vram_rd_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tag_pipe (
    .clk         (clk),
    .clr         (nrst),
    .in_valid    (rd_issue_q),
    .in_disp     (rd_disp_q),
    .disp_rvalid (disp_rvalid),
    .host_rvalid (host_rvalid)
  );

  assign bus.disp_ack    = disp_ack;
  assign bus.host_ack    = host_ack;
  assign bus.mem_ce      = mem_ce_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.disp_rvalid = disp_rvalid;
  assign bus.host_rvalid = host_rvalid;
  assign bus.disp_rdata  = disp_rvalid ? bus.mem_rdata : '0;
  assign bus.host_rdata  = host_rvalid ? bus.mem_rdata : '0;

endmodule

`default_nettype wire
